match_result_buffer: RTL
========================

Name: match_result_buffer

Overview:
- Parametrised successor to the stereo-matcher output stage. Accepts packed match tuples (left point, right point, parallax) from the matcher, checks them against epipolar and disparity limits, and stores accepted ones in a FIFO.
- Drains results over a valid/ready stream and reports per-frame accept/reject/drop counts.
- Sits between the matcher top and the host/UART readout.

Parameters:
- COORD_W, 10, bits per coordinate field.
- DEPTH, 64, FIFO entries; power of two, ≥ 4.
- CNT_W, 16, width of statistics counters (saturating).
- Y_TOL, 1, max allowed |Ly − Ry| for acceptance.
- DISP_MIN, 0, min allowed disparity Lx − Rx (signed).
- DISP_MAX, 63, max allowed disparity Lx − Rx (signed).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse: clear counters and FIFO, begin a frame.
- in_valid, in, 1, input tuple valid. No backpressure; the matcher cannot stall.
- in_data, in, 6*COORD_W, packed {Rx,Ry,Px,Py,Lx,Ly}, MSB first. Ly is in [COORD_W-1:0].
- frame_end, in, 1, pulse: last tuple of the frame has been presented.
- out_valid, out, 1, output tuple valid.
- out_ready, in, 1, consumer accepts.
- out_data, out, 4*COORD_W+COORD_W+1, {Lx,Ly,Rx,Ry,disp}; disp is signed, COORD_W+1 bits.
- busy, out, 1, high in COLLECT or DRAIN.
- done, out, 1, one-cycle pulse when DRAIN completes.
- acc_cnt / rej_cnt / drop_cnt, out, CNT_W each, frame statistics.

Behaviour:
- Reset: rst is synchronous and active-high. All outputs are 0, state is IDLE, FIFO is empty, counters are 0.
- State IDLE:
  - in_valid is ignored.
  - start → COLLECT, with counters cleared and FIFO pointers cleared in the same cycle.
- State COLLECT:
  - Each in_valid cycle is classified combinationally:
    - disp = Lx − Rx, zero-extended to COORD_W+1, then subtracted.
    - Accept iff |Ly − Ry| ≤ Y_TOL and DISP_MIN ≤ disp ≤ DISP_MAX.
  - Accepted and FIFO not full → write; acc_cnt++.
  - Accepted and FIFO full → discard; drop_cnt++.
  - Rejected → rej_cnt++.
  - frame_end → DRAIN. A tuple arriving in the same cycle as frame_end is processed first.
- State DRAIN:
  - in_valid is ignored.
  - When the FIFO is empty and no handshake is pending → pulse done, go to IDLE.
- Stream side:
  - out_valid = FIFO not empty (registered read, first-word-fall-through).
  - An entry pops on out_valid && out_ready.
  - out_data is stable while out_valid && !out_ready.
  - Draining is allowed in COLLECT and DRAIN.
- Latency: an accepted tuple written in cycle N gives out_valid in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop when full: the pop frees the slot and the push succeeds (no drop).
- Simultaneous push and pop when empty: the push is written; out_valid rises next cycle.
- Counters saturate at 2^CNT_W − 1; they do not wrap.
- start in COLLECT or DRAIN: abort the frame, flush the FIFO, clear counters, re-enter COLLECT. done is not pulsed.
- rst mid-frame: immediate return to the reset state.
- Pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare.

Optional Feature:
- MATCH_DEDUP_EN defined:
  - Keep the {Lx,Ly} of the last accepted tuple in a register.
  - An otherwise-accepted tuple with identical {Lx,Ly} is rejected: counted in rej_cnt, not written.
  - The register is cleared on start/rst; the first tuple of a frame is never a duplicate.
- MATCH_DEDUP_EN undefined: no dedup register; duplicates are accepted normally.

Decomposition:
- Package match_pkg holds:
  - COORD_W default and field offset constants (LY_LSB, LX_LSB, PY_LSB, PX_LSB, RY_LSB, RX_LSB).
  - Enum state_t {IDLE, COLLECT, DRAIN}.
  - Struct match_out_t {Lx, Ly, Rx, Ry, disp}.
- One sub-module, match_sync_fifo (parametrised WIDTH/DEPTH, FWFT), instantiated once.
- Filter logic and FSM stay in the top module.

Test Plan:
- Basic accept: start, then tuple Lx=100,Ly=50,Rx=80,Ry=50, then frame_end, with out_ready=1 → out_data {100,50,80,50,disp=20}; acc_cnt=1; done pulses 1 cycle after the pop.
- Filter rejects (Y_TOL=1, DISP 0..63):
  - Ly=50,Ry=53 → rejected.
  - Lx=10,Rx=20 (disp −10) → rejected.
  - Lx=200,Rx=100 (disp 100) → rejected.
  - Result: rej_cnt=3, acc_cnt=0, out_valid never rises.
- Overflow: DEPTH=4, out_ready=0, 6 valid accepted tuples → acc_cnt=4, drop_cnt=2. Then out_ready=1 → 4 pops in input order, then done.
- Backpressure: toggle out_ready randomly with 20 accepted tuples → out_data is held while stalled, and the output sequence is identical to the input order.
- Abort: start reasserted mid-COLLECT with 3 entries queued → FIFO empty next cycle, counters 0, no done pulse.
- With MATCH_DEDUP_EN: two consecutive tuples with Lx=100,Ly=50 → acc_cnt=1, rej_cnt=1.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and constants for the stereo-match result buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package match_pkg;

    // Default coordinate width for the matcher datapath
    localparam int COORD_W_DEF = 10;

    // Field offsets inside the packed input tuple {Rx,Ry,Px,Py,Lx,Ly}
    localparam int LY_LSB = 0 * COORD_W_DEF;
    localparam int LX_LSB = 1 * COORD_W_DEF;
    localparam int PY_LSB = 2 * COORD_W_DEF;
    localparam int PX_LSB = 3 * COORD_W_DEF;
    localparam int RY_LSB = 4 * COORD_W_DEF;
    localparam int RX_LSB = 5 * COORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Output record at the default coordinate width; disp is Lx - Rx
    typedef struct packed {
        logic [COORD_W_DEF-1:0]      lx;
        logic [COORD_W_DEF-1:0]      ly;
        logic [COORD_W_DEF-1:0]      rx;
        logic [COORD_W_DEF-1:0]      ry;
        logic signed [COORD_W_DEF:0] disp;
    } match_out_t;

endpackage

// File: rtl/match_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with clear; head is read from storage flops.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy low when full unless a pop happens in the same cycle.
module match_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]  wr_ptr_d, wr_ptr_q;
    logic [ADDR_W:0]  rd_ptr_d, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, push, pop;

    // Extra pointer MSB separates full (wrapped) from empty (equal)
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign pop    = rd_rdy && !empty && !clr;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write
    assign wr_rdy = !full || pop;
    assign push   = wr_vld && wr_rdy && !clr;
    assign rd_vld = !empty;
    assign rd_dat = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign count  = wr_ptr_q - rd_ptr_q;

    // Next-pointer computation; clear wins over any traffic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/match_result_buffer.sv
// Filters stereo match tuples (epipolar |Ly-Ry|, disparity window), queues accepted ones, drains them per frame.
// Latency: accepted tuple appears on out_valid one cycle after arrival when the queue was empty.
// Backpressure: input cannot stall (full queue drops and counts); output is valid/ready. MATCH_DEDUP_EN rejects repeated {Lx,Ly}.
module match_result_buffer
    import match_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int DEPTH    = 64,
    parameter int CNT_W    = 16,
    parameter int Y_TOL    = 1,
    parameter int DISP_MIN = 0,
    parameter int DISP_MAX = 63
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [6*COORD_W-1:0]   in_data,
    input  logic                   frame_end,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [5*COORD_W:0]     out_data,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       acc_cnt,
    output logic [CNT_W-1:0]       rej_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int OUT_W  = 5 * COORD_W + 1;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic        [COORD_W:0] Y_TOL_C    = (COORD_W+1)'(Y_TOL);
    localparam logic signed [COORD_W:0] DISP_MIN_C = (COORD_W+1)'(DISP_MIN);
    localparam logic signed [COORD_W:0] DISP_MAX_C = (COORD_W+1)'(DISP_MAX);

    // Saturating increment for the statistics counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Tuple fields
    logic [COORD_W-1:0] lx, ly, px, py, rx, ry;
    assign ly = in_data[0*COORD_W +: COORD_W];
    assign lx = in_data[1*COORD_W +: COORD_W];
    assign py = in_data[2*COORD_W +: COORD_W];
    assign px = in_data[3*COORD_W +: COORD_W];
    assign ry = in_data[4*COORD_W +: COORD_W];
    assign rx = in_data[5*COORD_W +: COORD_W];

    // Parallax fields are carried by the matcher but not used here
    logic unused_parallax;
    assign unused_parallax = ^{px, py};

    // Classification
    logic signed [COORD_W:0] ly_diff, disp;
    logic        [COORD_W:0] dy_abs;
    logic                    y_ok, disp_ok, is_dup, accept;

    assign ly_diff = $signed({1'b0, ly}) - $signed({1'b0, ry});
    assign dy_abs  = ly_diff[COORD_W] ? $unsigned(-ly_diff) : $unsigned(ly_diff);
    assign disp    = $signed({1'b0, lx}) - $signed({1'b0, rx});
    assign y_ok    = (dy_abs <= Y_TOL_C);
    assign disp_ok = (disp >= DISP_MIN_C) && (disp <= DISP_MAX_C);
    assign accept  = y_ok && disp_ok && !is_dup;

    state_t state_d, state_q;
    logic   in_take, push_req, pop, fifo_wr_rdy, drain_empty_next;
    logic [ADDR_W:0] fifo_count;

    // A start pulse overrides any tuple presented in the same cycle
    assign in_take  = (state_q == COLLECT) && in_valid && !start;
    assign push_req = in_take && accept;
    assign pop      = out_valid && out_ready;
    // In DRAIN nothing is pushed, so the queue empties after this cycle iff this pops the last entry
    assign drain_empty_next = !out_valid || ((fifo_count == (ADDR_W+1)'(1)) && pop);

`ifdef MATCH_DEDUP_EN
    logic [2*COORD_W-1:0] last_d, last_q;
    logic                 last_vld_d, last_vld_q;

    assign is_dup = last_vld_q && (last_q == {lx, ly});

    // Remember {Lx,Ly} of the most recent accepted tuple; forgotten at frame start
    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (start) begin
            last_d     = '0;
            last_vld_d = 1'b0;
        end else if (push_req) begin
            last_d     = {lx, ly};
            last_vld_d = 1'b1;
        end
    end

    // Dedup register
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // Result queue
    match_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (start),
        .wr_vld (push_req),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat ({lx, ly, rx, ry, disp}),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (out_data),
        .count  (fifo_count)
    );

    logic [CNT_W-1:0] acc_d, acc_q, rej_d, rej_q, drop_d, drop_q;
    logic             busy_d, busy_q, done_d, done_q;

    // Frame FSM next state, statistics and registered status outputs
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rej_d   = rej_q;
        drop_d  = drop_q;
        done_d  = 1'b0;
        if (start) begin
            state_d = COLLECT;
            acc_d   = '0;
            rej_d   = '0;
            drop_d  = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (in_take) begin
                        if (!accept)          rej_d  = sat_inc(rej_q);
                        else if (fifo_wr_rdy) acc_d  = sat_inc(acc_q);
                        else                  drop_d = sat_inc(drop_q);
                    end
                    if (frame_end) state_d = DRAIN;
                end
                DRAIN: begin
                    if (drain_empty_next) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // FSM and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rej_q   <= '0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rej_q   <= rej_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign acc_cnt  = acc_q;
    assign rej_cnt  = rej_q;
    assign drop_cnt = drop_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
